reset_sequencer: RTL and testbench

- Central reset controller for the Apple-1 core.
- Merges several reset requesters into one reset event: power-on, OSD menu reset, keyboard reset key and ROM download.
- Holds all subsystem resets for a minimum time, then releases them one stage at a time in a fixed order: memory/video first, then peripherals, then the CPU.
- Runs on the 14 MHz master clock and times its intervals on the system clock-enable.

---
 rtl/reset_sequencer_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/reset_sequencer.sv | 154 +++++++++++++++
 tb/tb_reset_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the Apple-1 reset sequencer: FSM states, stage
// and source index constants, and the interval counter sizing helper.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  // Stage indices, in release order
  localparam int STG_MEM    = 0;
  localparam int STG_PERIPH = 1;
  localparam int STG_CPU    = 2;

  // Reset request source indices; the power-on flag sits above them in cause
  localparam int SRC_OSD   = 0;
  localparam int SRC_KBD   = 1;
  localparam int SRC_DL    = 2;
  localparam int SRC_EXT   = 3;
  localparam int NSRC_DEF  = 4;
  localparam int CAUSE_POR = NSRC_DEF;

  // Counter width able to hold max(hold, gap)-1, never narrower than 1 bit
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for level signals crossing into the local clock
// domain. Each bit is synchronized independently; resets to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage shift; with
      // blocking ones both flops would load d_i on the same edge.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: merges reset requesters into one reset event,
// holds every stage for HOLD_CYCLES enable ticks after the last request
// drops, then releases stages in ascending order STAGE_GAP ticks apart.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int NSTAGE      = 3,
  parameter int HOLD_CYCLES = 64,
  parameter int STAGE_GAP   = 16
) (
  input  logic              clk14,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NSRC-1:0]   req,
  input  logic [NSRC-1:0]   req_mask,
  output logic [NSTAGE-1:0] stage_rst,
  output logic              busy,
  output logic              done,
  output logic [NSRC:0]     cause
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IDX_W = $clog2(NSTAGE + 1);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NSTAGE - 1);
  localparam logic [NSTAGE-1:0] ALL_ON    = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NSTAGE-1:0] stage_q, stage_d;
  logic              done_q, done_d;
  logic [NSRC:0]     cause_q, cause_d;

  logic [NSRC-1:0]   req_s;
  logic [NSRC-1:0]   hits;
  logic              act;

  sync_2ff #(
    .WIDTH (NSRC)
  ) u_req_sync (
    .clk   (clk14),
    .rst_n (rst_n),
    .d_i   (req),
    .q_o   (req_s)
  );

  // A masked source is treated exactly like a deasserted one
  assign hits = req_s & req_mask;
  assign act  = |hits;

  // Next-state logic: requests always win over the interval counter
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = 1'b0;
    cause_d = cause_q;

    unique case (state_q)
      ASSERT: begin
        stage_d = ALL_ON;
        if (act) begin
          cnt_d   = '0;
          cause_d = cause_q | {1'b0, hits};
        end else if (enable) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (NSTAGE == 1) begin
              stage_d = '0;
              done_d  = 1'b1;
              state_d = RUN;
            end else begin
              stage_d[STG_MEM] = 1'b0;
              idx_d            = IDX_W'(1);
              state_d          = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      RELEASE: begin
        if (act) begin
          stage_d = ALL_ON;
          cnt_d   = '0;
          cause_d = cause_q | {1'b0, hits};
          state_d = ASSERT;
        end else if (enable) begin
          if (cnt_q == GAP_LAST) begin
            stage_d = stage_q & ~(NSTAGE'(1) << idx_q);
            cnt_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              done_d  = 1'b1;
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      RUN: begin
        stage_d = '0;
        if (act) begin
          // A fresh event starts from a clean cause record
          stage_d = ALL_ON;
          cnt_d   = '0;
          cause_d = {1'b0, hits};
          state_d = ASSERT;
        end
      end

      default: begin
        stage_d = ALL_ON;
        cnt_d   = '0;
        state_d = ASSERT;
      end
    endcase
  end

  // State and output registers; power-on is recorded as the reset cause
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= ALL_ON;
      done_q  <= 1'b0;
      cause_q <= {1'b1, {NSRC{1'b0}}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign stage_rst = stage_q;
  assign busy      = |stage_q;
  assign done      = done_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with short intervals. A reference
// model tracks the reset event as "enable ticks since the last request"
// and derives how many stages are released from that count.
module tb_reset_sequencer;

  localparam int NSRC   = 4;
  localparam int NSTAGE = 3;
  localparam int HOLD   = 4;
  localparam int GAP    = 2;

  logic              clk14 = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [NSRC-1:0]   req;
  logic [NSRC-1:0]   req_mask;
  logic [NSTAGE-1:0] stage_rst;
  logic              busy;
  logic              done;
  logic [NSRC:0]     cause;

  int n_checks;
  int n_errors;

  reset_sequencer #(
    .NSRC        (NSRC),
    .NSTAGE      (NSTAGE),
    .HOLD_CYCLES (HOLD),
    .STAGE_GAP   (GAP)
  ) dut (
    .clk14     (clk14),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .req_mask  (req_mask),
    .stage_rst (stage_rst),
    .busy      (busy),
    .done      (done),
    .cause     (cause)
  );

  always #5 clk14 = ~clk14;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_in_event;
  int              m_ticks;
  logic [NSRC:0]   m_cause;
  bit              m_done;
  logic [NSRC-1:0] m_s0, m_s1;

  function automatic int released(input int t);
    int r;
    if (t < HOLD) return 0;
    r = 1 + (t - HOLD) / GAP;
    return (r > NSTAGE) ? NSTAGE : r;
  endfunction

  task automatic model_reset();
    m_in_event = 1'b1;
    m_ticks    = 0;
    m_cause    = 5'b10000;
    m_done     = 1'b0;
    m_s0       = '0;
    m_s1       = '0;
  endtask

  task automatic model_edge(input logic [NSRC-1:0] r, input logic [NSRC-1:0] m, input logic e);
    logic [NSRC-1:0] hits;
    hits   = m_s1 & m;
    m_done = 1'b0;
    if (hits != '0) begin
      if (m_in_event) m_cause = m_cause | {1'b0, hits};
      else            m_cause = {1'b0, hits};
      m_in_event = 1'b1;
      m_ticks    = 0;
    end else if (m_in_event && e) begin
      m_ticks++;
      if (released(m_ticks) == NSTAGE) begin
        m_in_event = 1'b0;
        m_done     = 1'b1;
      end
    end
    m_s1 = m_s0;
    m_s0 = r;
  endtask

  task automatic check_model();
    logic [NSTAGE-1:0] exp_stage;
    exp_stage = m_in_event ? NSTAGE'((1 << NSTAGE) - (1 << released(m_ticks))) : '0;
    check("stage_rst", 32'(stage_rst), 32'(exp_stage));
    check("busy", 32'(busy), 32'(m_in_event));
    check("done", 32'(done), 32'(m_done));
    check("cause", 32'(cause), 32'(m_cause));
  endtask

  // One clk14 cycle: drive inputs, clock, advance the model, compare
  task automatic step(input logic [NSRC-1:0] r, input logic [NSRC-1:0] m, input logic e);
    req      = r;
    req_mask = m;
    enable   = e;
    @(posedge clk14);
    model_edge(r, m, e);
    #1;
    check_model();
  endtask

  // Asserts rst_n between edges and releases it just after an edge ("edge 0")
  task automatic apply_reset();
    @(posedge clk14);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("rst_stage", 32'(stage_rst), 32'h7);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_cause", 32'(cause), 32'h10);
    model_reset();
    repeat (2) @(posedge clk14);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [NSTAGE-1:0] pon_stage(input int e);
    if (e < 4) return 3'b111;
    if (e < 6) return 3'b110;
    if (e < 8) return 3'b100;
    return 3'b000;
  endfunction

  initial begin
    logic [NSRC-1:0] r_rand;
    logic [NSRC-1:0] m_rand;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    req      = '0;
    req_mask = '1;
    enable   = 1'b1;
    model_reset();

    // Power-on sequence with fixed expectations
    apply_reset();
    for (int e = 1; e <= 8; e++) begin
      step('0, 4'hF, 1'b1);
      check("pon_stage", 32'(stage_rst), 32'(pon_stage(e)));
    end
    check("pon_done", 32'(done), 32'h1);
    check("pon_cause", 32'(cause), 32'h10);
    step('0, 4'hF, 1'b1);
    check("pon_done_low", 32'(done), 32'h0);

    // Keyboard reset from RUN, one-cycle request
    step(4'b0010, 4'hF, 1'b1);
    step('0, 4'hF, 1'b1);
    check("kbd_latency2", 32'(stage_rst), 32'h0);
    step('0, 4'hF, 1'b1);
    check("kbd_stage", 32'(stage_rst), 32'h7);
    check("kbd_cause", 32'(cause), 32'h02);
    repeat (4) step('0, 4'hF, 1'b1);
    check("kbd_rel0", 32'(stage_rst), 32'h6);

    // Re-trigger during RELEASE from OSD
    step(4'b0001, 4'hF, 1'b1);
    step('0, 4'hF, 1'b1);
    step('0, 4'hF, 1'b1);
    check("retrig_stage", 32'(stage_rst), 32'h7);
    check("retrig_cause", 32'(cause), 32'h03);
    repeat (20) step('0, 4'hF, 1'b1);

    // Masked source in RUN has no effect
    repeat (6) begin
      step(4'b0100, 4'b1011, 1'b1);
      check("mask_stage", 32'(stage_rst), 32'h0);
      check("mask_busy", 32'(busy), 32'h0);
      check("mask_cause", 32'(cause), 32'h03);
    end
    repeat (3) step('0, 4'hF, 1'b1);

    // Enable high one cycle in four
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      step('0, 4'hF, (i % 4) == 0);
      if (i == 11) check("en_hold", 32'(stage_rst), 32'h7);
      if (i == 12) check("en_rel0", 32'(stage_rst), 32'h6);
      if (i == 28) begin
        check("en_rel2", 32'(stage_rst), 32'h0);
        check("en_done", 32'(done), 32'h1);
      end
    end

    // Enable held low: everything stays asserted
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      step('0, 4'hF, 1'b0);
      check("en0_stage", 32'(stage_rst), 32'h7);
    end

    // Asynchronous reset mid-RELEASE
    apply_reset();
    repeat (6) step('0, 4'hF, 1'b1);
    check("mid_stage", 32'(stage_rst), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_stage", 32'(stage_rst), 32'h7);
    check("async_done", 32'(done), 32'h0);
    check("async_cause", 32'(cause), 32'h10);
    model_reset();
    @(posedge clk14);
    #2;
    rst_n = 1'b1;
    repeat (10) step('0, 4'hF, 1'b1);

    // Randomized traffic: sparse requests, occasional mask changes, gated enable
    m_rand = '1;
    for (int i = 0; i < 4000; i++) begin
      r_rand = '0;
      for (int b = 0; b < NSRC; b++)
        if ($urandom_range(23) == 0) r_rand[b] = 1'b1;
      if ($urandom_range(49) == 0) m_rand = NSRC'($urandom_range(15));
      step(r_rand, m_rand, $urandom_range(3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
